// File: rtl/proc_pkg.sv
// Shared processor definitions: widths, instruction size, halt encoding, fetch states.
package proc_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INST_BYTES   = 4;
  localparam logic [XLEN_DEFAULT-1:0] HALT_WORD = '0;

  typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO with flush and occupancy count; the caller guarantees no push when full
// and no pop when empty.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_q, rd_q;
  logic [CW-1:0]               cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited in-order requests, pc tag FIFO,
// prefetch queue to decode, redirect with in-flight discard, and halt on the zero word.
module fetch_unit import proc_pkg::*; #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t        state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [CW-1:0]       out_q, out_d, disc_q, disc_d;
  logic [CW-1:0]       occ, tag_cnt;
  logic [XLEN-1:0]     tag_head;
  logic [2*XLEN-1:0]   q_head;
  logic                issue, resp_live, halt_hit, push, pop;

  // Queued words plus in-flight requests never exceed DEPTH, so every response has room.
  assign req_valid = rst_n && (state_q == RUN) && !redirect_valid &&
                     (({1'b0, occ} + {1'b0, out_q}) < (CW+1)'(DEPTH));
  assign req_addr  = pc_q;
  assign issue     = req_valid && req_ready;

  assign resp_live = resp_valid && (disc_q == '0) && !redirect_valid;
  assign halt_hit  = resp_live && (state_q == RUN) && (resp_data == XLEN'(HALT_WORD));
  assign push      = resp_live && (state_q == RUN) && !halt_hit;
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    disc_d  = disc_q;
    out_d   = out_q + CW'(issue) - CW'(resp_valid);
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = RUN;
      disc_d  = out_q - CW'(resp_valid);
    end else begin
      if (issue) pc_d = pc_q + XLEN'(INST_BYTES);
      if (resp_valid && (disc_q != '0)) disc_d = disc_q - 1'b1;
      if (halt_hit) state_d = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  // Tags are popped only by responses that survive discard, keeping them aligned with words.
  fetch_queue #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (issue),
    .push_data_i (pc_q),
    .pop_i       (resp_live),
    .head_o      (tag_head),
    .count_o     (tag_cnt)
  );

  fetch_queue #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_insts (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({resp_data, tag_head}),
    .pop_i       (pop),
    .head_o      (q_head),
    .count_o     (occ)
  );

  always_ff @(posedge clk) begin
    if (rst_n && resp_live) assert (tag_cnt != '0);
  end

  assign inst_valid = (occ != '0);
  assign inst_data  = inst_valid ? q_head[2*XLEN-1:XLEN] : '0;
  assign inst_pc    = inst_valid ? q_head[XLEN-1:0] : '0;
  assign halted     = (state_q == HALTED);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;
  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t       mq[$];
  int          n_cmp, n_bad, cyc, lat, n_acc;
  logic [31:0] halt_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'h0;
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_0003;
      default: return 32'h1000_0000 | a;
    endcase
  endfunction

  // Entered just after a rising edge; leaves just after the next one.
  task automatic tick();
    #1;
    if (req_valid && req_ready) begin
      mq.push_back('{addr: req_addr, due: cyc + lat});
      n_acc++;
    end
    @(posedge clk); #1;
    cyc++;
    resp_valid = 1'b0;
    resp_data  = '0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_ready = 1'b0; inst_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mq.delete(); halt_addr = 32'hFFFF_FFFF; lat = 1; n_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %0b want 0", req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got data %h pc %h want 0 0", inst_data, inst_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
    do_reset();
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_release: got rv %0b addr %h want 1 0", req_valid, req_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'(4*k)) begin n_bad++; $display("FAIL stream_req[%0d]: got rv %0b addr %h want 1 %h", k, req_valid, req_addr, 32'(4*k)); end
      tick();
      if (k == 0) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid: got %0b want 0", inst_valid); end
      end else begin
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(k-1)) || inst_data !== mem_word(32'(4*(k-1))))
          begin n_bad++; $display("FAIL stream_inst[%0d]: got v %0b pc %h data %h want pc %h", k, inst_valid, inst_pc, inst_data, 32'(4*(k-1))); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b0;
    repeat (10) tick();
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL bp_requests: got %0d want 4", n_acc); end
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %0b want 0", req_valid); end
    n_cmp++; if (dut.occ !== 3'd4) begin n_bad++; $display("FAIL bp_occupancy: got %0d want 4", dut.occ); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head: got %h want 0", inst_pc); end
    inst_ready = 1'b1;
    tick();
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h10) begin n_bad++; $display("FAIL bp_resume: got rv %0b addr %h want 1 10", req_valid, req_addr); end
    n_cmp++; if (inst_pc !== 32'h4) begin n_bad++; $display("FAIL bp_next_head: got %h want 4", inst_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3; req_ready = 1'b1; inst_ready = 1'b1;
    tick(); tick();
    req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_no_issue: got %0b want 0", req_valid); end
    req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (dut.disc_q !== 3'd2) begin n_bad++; $display("FAIL redir_discard: got %0d want 2", dut.disc_q); end
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h40) begin n_bad++; $display("FAIL redir_new_req: got rv %0b addr %h want 1 40", req_valid, req_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL redir_dropped[%0d]: got v %0b pc %h want 0", k, inst_valid, inst_pc); end
    end
    tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'h1000_0040)
      begin n_bad++; $display("FAIL redir_first: got v %0b pc %h data %h want 1 40 10000040", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_halt();
    int acc0;
    do_reset();
    halt_addr = 32'h8; req_ready = 1'b1; inst_ready = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early: got %0b want 0", halted); end
    tick();
    acc0 = n_acc;
    n_cmp++; if (halted !== 1'b1 || req_valid !== 1'b0) begin n_bad++; $display("FAIL halt_rise: got halted %0b rv %0b want 1 0", halted, req_valid); end
    n_cmp++; if (dut.occ !== 3'd2) begin n_bad++; $display("FAIL halt_occ: got %0d want 2", dut.occ); end
    inst_ready = 1'b1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL halt_drain0: got v %0b pc %h want 1 0", inst_valid, inst_pc); end
    tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h2009_0003)
      begin n_bad++; $display("FAIL halt_drain4: got v %0b pc %h data %h want 1 4 20090003", inst_valid, inst_pc, inst_data); end
    tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL halt_zero_delivered: got v %0b pc %h want 0", inst_valid, inst_pc); end
    tick(); tick();
    n_cmp++; if (n_acc !== acc0 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_stopped: got reqs %0d halted %0b want %0d 1", n_acc, halted, acc0); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h100)
      begin n_bad++; $display("FAIL halt_leave: got halted %0b rv %0b addr %h want 0 1 100", halted, req_valid, req_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2; req_ready = 1'b1; inst_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || resp_valid !== 1'b1)
      begin n_bad++; $display("FAIL b2b_setup: got v %0b pc %h resp %0b want 1 0 1", inst_valid, inst_pc, resp_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_flush: got v %0b want 0", inst_valid); end
    n_cmp++; if (dut.disc_q !== 3'd1 || dut.out_q !== 3'd1) begin n_bad++; $display("FAIL b2b_counts: got discard %0d outstanding %0d want 1 1", dut.disc_q, dut.out_q); end
    tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop: got v %0b pc %h want 0", inst_valid, inst_pc); end
    tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== 32'h1000_0200)
      begin n_bad++; $display("FAIL b2b_first: got v %0b pc %h data %h want 1 200 10000200", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    halt_addr = 32'h8; req_ready = 1'b1; inst_ready = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0)
      begin n_bad++; $display("FAIL areset_ctrl: got rv %0b iv %0b halted %0b want 0 0 0", req_valid, inst_valid, halted); end
    n_cmp++; if (inst_data !== 32'h0 || inst_pc !== 32'h0 || dut.occ !== 3'd0)
      begin n_bad++; $display("FAIL areset_data: got data %h pc %h occ %0d want 0 0 0", inst_data, inst_pc, dut.occ); end
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    n_cmp++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_bad++; $display("FAIL areset_restart: got rv %0b addr %h want 1 0", req_valid, req_addr); end
    tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL areset_first: got v %0b pc %h want 1 0", inst_valid, inst_pc); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; n_acc = 0; halt_addr = 32'hFFFF_FFFF;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the processor, replacing the bare PC register and +4 adder with a decoupled fetch stage. It issues in-order word requests to a variable-latency instruction memory, buffers returned words in a prefetch queue, and hands them to decode with a valid/ready handshake. It also accepts branch/jump redirects and stops fetching when the halt word (all-zero instruction) arrives.

## Interface
- XLEN, 32: address and instruction width.
- RESET_PC, 0: fetch address after reset.
- DEPTH, 4: prefetch queue entries; power of two, at least 2; also caps requests in flight.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  XLEN  word address (byte address, low 2 bits 0).
- resp_valid  in  1  one returned word, in request order, no backpressure.
- resp_data  in  XLEN  returned instruction.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes head.
- inst_data  out  XLEN  head instruction.
- inst_pc  out  XLEN  address of head instruction.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  XLEN  new fetch address.
- halted  out  1  halt word seen; fetching stopped.

## Operation
- Registers: fetch_pc, queue (data+pc per entry), occupancy, outstanding, discard, state ∈ {RUN, HALTED}.
- Issue: req_valid = (state==RUN) && !redirect_valid && (occupancy + outstanding < DEPTH); req_addr = fetch_pc. On req_valid && req_ready: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
- Each request records its address in a DEPTH-entry pc tag FIFO so inst_pc pairs with its word.
- Response: outstanding -= 1. If discard > 0: discard -= 1, word dropped. Else if state==HALTED: dropped. Else if resp_data == 0: word not queued, state → HALTED. Else word and tag pushed; room is guaranteed by the credit rule.
- Delivery: inst_valid = occupancy > 0; pop on inst_valid && inst_ready.
- Redirect (priority over all else that cycle): queue flushed, fetch_pc ← redirect_pc, state → RUN, discard ← outstanding minus any response arriving this cycle (that response is also dropped), no request issued. Pop in the redirect cycle is ignored.
- HALTED: no requests; queue still drains to decode; only redirect or reset leaves it.
- Simultaneous issue, response and pop in one cycle: all counters update consistently (net change).

## Timing
- Reset (async assert, sync release): fetch_pc=RESET_PC, occupancy=outstanding=discard=0, state=RUN; req_valid=0 while rst_n low, 1 in the first cycle after release (req_addr=RESET_PC); inst_valid=0, inst_data=0, inst_pc=0, halted=0.
- Reset mid-operation clears everything immediately; later responses from the old epoch are the memory's responsibility to suppress.
- Latency: resp_valid at edge N → inst_valid at N+1 (queue empty). Redirect at edge N → first new request visible N+1.
- Sustained throughput 1 instruction/cycle when memory returns 1/cycle and inst_ready=1, provided memory latency < DEPTH.
- halted rises the cycle after the zero word's response.

## Structure
- Shared package proc_pkg: XLEN default, INST_BYTES=4, HALT_WORD=0, fetch_state_t enum {RUN, HALTED}.
- Sub-module fetch_queue: circular FIFO, parameters WIDTH/DEPTH, push/pop/flush, occupancy output; instantiated for data+pc (or data and tags separately).

## Test plan
- Reset release, memory latency 1, inst_ready=1, words 0x20080005,0x20090003,… → requests 0x0,0x4,0x8,…; inst_pc 0x0,0x4 back-to-back, one per cycle.
- inst_ready=0, latency 1, DEPTH=4 → exactly 4 requests then req_valid=0; occupancy 4; releasing ready resumes issue the following cycle.
- Latency 3, redirect to 0x40 with 2 requests outstanding → 2 responses dropped, queue flushed, next inst_pc=0x40.
- Response word 0x00000000 at address 0x8 → halted=1 next cycle, no further requests, queued words from 0x0/0x4 still delivered, zero never delivered; redirect to 0x100 clears halted.
- Redirect, response and pop all in the same cycle → response dropped, queue empty next cycle, discard = outstanding−1.
- rst_n low mid-burst → all outputs at reset values asynchronously; restart from RESET_PC.
